// File: rtl/mem_responder.sv
// mem_responder: single-port word memory acting as the responder on the CPU
// memory bus. One request is served at a time through a req/ready handshake,
// with WAIT_CYCLES wait states inserted before each access.
// Optional feature macro: MEM_PARITY_EN (even parity per word, i_inj_perr port).
module mem_responder #(
  parameter int DWIDTH      = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0]     i_data,
`ifdef MEM_PARITY_EN
  input  logic                  i_inj_perr,
`endif
  output logic [DWIDTH-1:0]     o_data,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
`ifdef MEM_PARITY_EN
  localparam int WORD_W = DWIDTH + 1;
`else
  localparam int WORD_W = DWIDTH;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t                state;
  state_t                state_nx;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [DWIDTH-1:0]     lat_data;
  logic                  in_range;
  logic [IDX_W-1:0]      mem_idx;
  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     wr_word;
  logic                  rd_perr;

  // Storage is deliberately left out of reset so contents survive a reset.
  logic [WORD_W-1:0]     mem [MEM_DEPTH];

  assign in_range = ({1'b0, lat_addr} < DEPTH_LIM);
  assign mem_idx  = lat_addr[IDX_W-1:0];
  assign rd_word  = mem[mem_idx];

`ifdef MEM_PARITY_EN
  // Even parity: the stored word XORs to zero unless a fault was injected.
  assign wr_word = {(^lat_data) ^ i_inj_perr, lat_data};
  assign rd_perr = ^rd_word;
`else
  assign wr_word = lat_data;
  assign rd_perr = 1'b0;
`endif

  // State register; an asynchronous reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state sequencing: accept, optional wait states, access, response.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_req) state_nx = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latching, wait counter and registered response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= 4'd0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_data  <= '0;
      o_data    <= '0;
      o_ready   <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_ready <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            lat_addr  <= i_addr;
            lat_write <= i_write;
            lat_data  <= i_data;
            o_busy    <= 1'b1;
            wait_cnt  <= CNT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        ACCESS: begin
          o_ready <= 1'b1;
          o_err   <= !in_range || (!lat_write && rd_perr);
          if (!lat_write) o_data <= in_range ? rd_word[DWIDTH-1:0] : '0;
        end
        RESP: begin
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Array write port; out-of-range writes are silently dropped.
  always_ff @(posedge clk) begin
    if (state == ACCESS && lat_write && in_range) mem[mem_idx] <= wr_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against a word-level memory model.
module tb_mem_responder;

  localparam int DEPTH  = 2048;
  localparam int WC     = 2;
  localparam int PERIOD = WC + 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_write = 1'b0;
  logic [11:0] i_addr = '0;
  logic [15:0] i_data = '0;
  logic        i_inj_perr = 1'b0;
  logic [15:0] o_data;
  logic        o_ready;
  logic        o_busy;
  logic        o_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] model_mem [4096];
  bit          model_valid [4096];
  bit          model_perr [4096];
  logic [15:0] last_read = '0;

  mem_responder #(
    .DWIDTH(16), .ADDR_WIDTH(12), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_write(i_write),
    .i_addr(i_addr), .i_data(i_data),
`ifdef MEM_PARITY_EN
    .i_inj_perr(i_inj_perr),
`endif
    .o_data(o_data), .o_ready(o_ready), .o_busy(o_busy), .o_err(o_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: accept, wait for the response, check it.
  task automatic applyStimulus(input logic wr, input logic [11:0] addr,
                               input logic [15:0] data, input logic inj);
    int   lat;
    bit   busy_gap;
    logic oor;
    logic exp_err;
    oor = (int'(addr) >= DEPTH);
    i_req = 1'b1; i_write = wr; i_addr = addr; i_data = data; i_inj_perr = inj;
    stepCycle();
    i_req = 1'b0;
    checkOutput("busy_at_accept", 32'(o_busy), 32'd1);
    lat = 1;
    busy_gap = 1'b0;
    while (!o_ready && lat < 20) begin
      i_addr = 12'($urandom); i_data = 16'($urandom); i_write = 1'($urandom);
      stepCycle();
      lat++;
      if (!o_busy) busy_gap = 1'b1;
    end
    checkOutput("latency", 32'(lat), 32'(WC + 2));
    checkOutput("busy_held", 32'(busy_gap), 32'd0);
    exp_err = oor;
    if (wr) begin
      if (!oor) begin
        model_mem[addr]   = data;
        model_valid[addr] = 1'b1;
        model_perr[addr]  = inj;
      end
    end else begin
      if (!oor) exp_err = model_perr[addr];
      last_read = oor ? 16'h0000 : model_mem[addr];
    end
    checkOutput("resp_err", 32'(o_err), 32'(exp_err));
    checkOutput("resp_data", 32'(o_data), 32'(last_read));
    i_inj_perr = 1'b0;
    stepCycle();
    checkOutput("ready_pulse_end", 32'(o_ready), 32'd0);
    checkOutput("busy_end", 32'(o_busy), 32'd0);
    checkOutput("data_hold", 32'(o_data), 32'(last_read));
  endtask

  // Main sequence.
  initial begin
    int  ready_seen;
    bit  exp_ready;
    logic [11:0] raddr;
    logic        rwr;

    #1;
    checkOutput("rst_data", 32'(o_data), 32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_err", 32'(o_err), 32'd0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    stepCycle();

    applyStimulus(1'b1, 12'h010, 16'hA5C3, 1'b0);
    applyStimulus(1'b0, 12'h010, 16'h0000, 1'b0);

    applyStimulus(1'b1, 12'h100, 16'hBEEF, 1'b0);
    applyStimulus(1'b1, 12'h900, 16'h1234, 1'b0);
    applyStimulus(1'b0, 12'h900, 16'h0000, 1'b0);
    applyStimulus(1'b0, 12'h100, 16'h0000, 1'b0);

    // Request held high: one access every PERIOD cycles, addresses only
    // matter at the accept edges.
    for (int a = 0; a < 3; a++) applyStimulus(1'b1, 12'(a), 16'(a + 1), 1'b0);
    i_req = 1'b1; i_write = 1'b0; i_addr = 12'h000;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      stepCycle();
      exp_ready = ((k % PERIOD) == WC + 1);
      checkOutput("b2b_ready", 32'(o_ready), 32'(exp_ready));
      if (exp_ready) checkOutput("b2b_data", 32'(o_data), 32'(k / PERIOD + 1));
      if ((k % PERIOD) == PERIOD - 1) begin
        i_addr = 12'(k / PERIOD + 1); i_write = 1'b0;
      end else begin
        i_addr = 12'($urandom_range(3, 2047)); i_write = 1'($urandom);
      end
      if (k == 2 * PERIOD + WC + 1) i_req = 1'b0;
    end
    last_read = 16'h0003;
    stepCycle();

    // Reset in the middle of a write's wait states discards the write.
    applyStimulus(1'b1, 12'h020, 16'h0001, 1'b0);
    i_req = 1'b1; i_write = 1'b1; i_addr = 12'h020; i_data = 16'hFFFF;
    stepCycle();
    i_req = 1'b0;
    stepCycle();
    reset_n = 1'b0;
    #2;
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    reset_n = 1'b1;
    last_read = 16'h0000;
    ready_seen = 0;
    for (int c = 0; c < 8; c++) begin
      stepCycle();
      if (o_ready) ready_seen++;
    end
    checkOutput("midrst_no_ready", 32'(ready_seen), 32'd0);
    checkOutput("midrst_data", 32'(o_data), 32'd0);
    applyStimulus(1'b0, 12'h020, 16'h0000, 1'b0);

`ifdef MEM_PARITY_EN
    applyStimulus(1'b1, 12'h030, 16'h0F0F, 1'b1);
    applyStimulus(1'b0, 12'h030, 16'h0000, 1'b0);
    applyStimulus(1'b1, 12'h030, 16'h0F0F, 1'b0);
    applyStimulus(1'b0, 12'h030, 16'h0000, 1'b0);
`endif

    // Randomized traffic over a small address pool plus out-of-range hits.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        raddr = 12'($urandom_range(DEPTH, 4095));
        rwr   = 1'($urandom);
      end else begin
        raddr = 12'($urandom_range(12'h200, 12'h20F));
        rwr   = !model_valid[raddr] || ($urandom_range(0, 1) == 1);
      end
      applyStimulus(rwr, raddr, 16'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
